ga_sync_irq: RTL and testbench

- Gate Array sync/interrupt stage, directly downstream of the CRTC.
- Consumes CRTC HSYNC/VSYNC at the 1 MHz character enable and produces the monitor HSYNC/VSYNC.
- Runs the 52-line raster interrupt counter (R52) with VSYNC resynchronisation and the CPU interrupt acknowledge.
- Latches the video mode at HSYNC start for the pixel serialiser.

---
 rtl/ga_sync_irq.sv | 181 ++++++++++++++++++
 tb/tb_ga_sync_irq.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/ga_sync_irq.sv
// ga_sync_irq: Gate Array sync / raster interrupt stage behind the CRTC.
// Turns CRTC HSYNC/VSYNC into monitor HSYNC/VSYNC, runs the 52-line interrupt
// counter (R52) with CPU acknowledge and RMR reset, and latches the video mode
// at HSYNC start.
// Optional feature macro: GA_VSYNC_IRQ_SYNC_EN -- when defined, a VSYNC rise
// resynchronises R52 VS_IRQ_DELAY HSYNC falls later (and may raise INT).
module ga_sync_irq #(
  parameter int IRQ_LINES    = 52,
`ifdef GA_VSYNC_IRQ_SYNC_EN
  parameter int VS_IRQ_DELAY = 2,
`endif
  parameter int GA_VS_LINES  = 26,
  parameter int HS_DELAY     = 2,
  parameter int HS_WIDTH     = 4
) (
  input  logic       CLOCK,
  input  logic       nRESET,
  input  logic       CLKEN,
  input  logic       HSYNC_IN,
  input  logic       VSYNC_IN,
  input  logic       INT_ACK,
  input  logic       RMR_WR,
  input  logic [4:0] RMR_DI,
  output logic       INT,
  output logic       HSYNC_OUT,
  output logic       VSYNC_OUT,
  output logic [1:0] MODE,
  output logic [5:0] R52
);

  localparam int VCW = $clog2(GA_VS_LINES + 1);
  localparam logic [6:0]     IRQ_N  = 7'(IRQ_LINES);
  localparam logic [3:0]     HS_SET = 4'(HS_DELAY - 1);
  localparam logic [3:0]     HS_CLR = 4'(HS_DELAY + HS_WIDTH - 1);
  localparam logic [VCW-1:0] VS_N   = VCW'(GA_VS_LINES);

  logic           hs_q, hs_d, vs_q, vs_d;
  logic           int_q, int_d;
  logic           hso_q, hso_d, vso_q, vso_d;
  logic [1:0]     mode_q, mode_d, pend_q, pend_d;
  logic [5:0]     r52_q, r52_d, r52_ack;
  logic [6:0]     r52_inc;
  logic [3:0]     hcnt_q, hcnt_d;
  logic [VCW-1:0] vcnt_q, vcnt_d;
  logic           hs_fall, hs_rise, vs_rise, vs_fall;
  logic           unused_rmr_bits;

`ifdef GA_VSYNC_IRQ_SYNC_EN
  localparam int VDW = $clog2(VS_IRQ_DELAY + 1);
  logic [VDW-1:0] vdly_q, vdly_d;
`endif

  // Edges are only meaningful on a character enable.
  assign hs_fall = CLKEN &  hs_q & ~HSYNC_IN;
  assign hs_rise = CLKEN & ~hs_q &  HSYNC_IN;
  assign vs_rise = CLKEN & ~vs_q &  VSYNC_IN;
  assign vs_fall = CLKEN &  vs_q & ~VSYNC_IN;

  // Mode bits 3:2 of RMR belong to the ROM mapping, not this stage.
  assign unused_rmr_bits = ^RMR_DI[3:2];

  // Acknowledge clears bit 5 before the counter sees this cycle's HS fall.
  assign r52_ack = INT_ACK ? {1'b0, r52_q[4:0]} : r52_q;
  assign r52_inc = {1'b0, r52_ack} + 7'd1;

  // Next-state logic: edge history, interrupt counter, mode, sync shaping.
  always_comb begin
    hs_d   = CLKEN ? HSYNC_IN : hs_q;
    vs_d   = CLKEN ? VSYNC_IN : vs_q;
    int_d  = int_q & ~INT_ACK;
    r52_d  = r52_ack;
    pend_d = pend_q;
    mode_d = mode_q;
    hcnt_d = hcnt_q;
    hso_d  = hso_q;
    vcnt_d = vcnt_q;
    vso_d  = vso_q;
`ifdef GA_VSYNC_IRQ_SYNC_EN
    vdly_d = vdly_q;
`endif

    // Raster counter: every HSYNC fall counts a line, wrap at IRQ_LINES fires INT.
    if (hs_fall) begin
      if (r52_inc == IRQ_N) begin
        r52_d = '0;
        int_d = 1'b1;
      end else begin
        r52_d = r52_inc[5:0];
      end
    end

`ifdef GA_VSYNC_IRQ_SYNC_EN
    // VSYNC resync: counts down HS falls after a VS rise, then clears R52 and
    // fires INT only if the counter was in its upper half (no short interrupt).
    if (hs_fall && (vdly_q != '0)) begin
      vdly_d = vdly_q - VDW'(1);
      if (vdly_q == VDW'(1)) begin
        if (r52_inc >= 7'd32) int_d = 1'b1;
        r52_d = '0;
      end
    end
    if (vs_rise) vdly_d = VDW'(VS_IRQ_DELAY);
`endif

    // RMR write has the final word over INT and R52.
    if (RMR_WR) begin
      pend_d = RMR_DI[1:0];
      if (RMR_DI[4]) begin
        r52_d = '0;
        int_d = 1'b0;
      end
    end

    // Mode is picked up at HSYNC start, including a same-cycle RMR write.
    if (hs_rise) mode_d = pend_d;

    // HSYNC character counter, saturating so long pulses cannot wrap.
    if (CLKEN && HSYNC_IN) begin
      if (hs_rise)               hcnt_d = '0;
      else if (hcnt_q != 4'hF)   hcnt_d = hcnt_q + 4'd1;
    end

    // Monitor HSYNC: starts HS_DELAY chars in, lasts at most HS_WIDTH chars.
    if (CLKEN) begin
      if (hs_fall)                                  hso_d = 1'b0;
      else if (hso_q && (hcnt_q == HS_CLR))         hso_d = 1'b0;
      else if (HSYNC_IN && !hs_rise && (hcnt_q == HS_SET)) hso_d = 1'b1;
    end

    // Monitor VSYNC: restarts on VS rise, ends on VS fall or after GA_VS_LINES.
    if (vs_rise) begin
      vso_d  = 1'b1;
      vcnt_d = '0;
    end else if (vs_fall) begin
      vso_d  = 1'b0;
    end else if (hs_fall && vso_q) begin
      vcnt_d = vcnt_q + VCW'(1);
      if (vcnt_d == VS_N) vso_d = 1'b0;
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge CLOCK or negedge nRESET) begin
    if (!nRESET) begin
      hs_q   <= 1'b0;
      vs_q   <= 1'b0;
      int_q  <= 1'b0;
      hso_q  <= 1'b0;
      vso_q  <= 1'b0;
      mode_q <= '0;
      pend_q <= '0;
      r52_q  <= '0;
      hcnt_q <= '0;
      vcnt_q <= '0;
`ifdef GA_VSYNC_IRQ_SYNC_EN
      vdly_q <= '0;
`endif
    end else begin
      hs_q   <= hs_d;
      vs_q   <= vs_d;
      int_q  <= int_d;
      hso_q  <= hso_d;
      vso_q  <= vso_d;
      mode_q <= mode_d;
      pend_q <= pend_d;
      r52_q  <= r52_d;
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
`ifdef GA_VSYNC_IRQ_SYNC_EN
      vdly_q <= vdly_d;
`endif
    end
  end

  assign INT       = int_q;
  assign HSYNC_OUT = hso_q;
  assign VSYNC_OUT = vso_q;
  assign MODE      = mode_q;
  assign R52       = r52_q;

endmodule

// File: tb/tb_ga_sync_irq.sv
// Bench for ga_sync_irq: vector tables plus hand-written multi-cycle sequences.
module tb_ga_sync_irq;

  logic       CLOCK = 1'b0;
  logic       nRESET = 1'b0;
  logic       CLKEN = 1'b0;
  logic       HSYNC_IN = 1'b0;
  logic       VSYNC_IN = 1'b0;
  logic       INT_ACK = 1'b0;
  logic       RMR_WR = 1'b0;
  logic [4:0] RMR_DI = 5'h00;
  logic       INT, HSYNC_OUT, VSYNC_OUT;
  logic [1:0] MODE;
  logic [5:0] R52;

  ga_sync_irq dut (
    .CLOCK(CLOCK), .nRESET(nRESET), .CLKEN(CLKEN),
    .HSYNC_IN(HSYNC_IN), .VSYNC_IN(VSYNC_IN), .INT_ACK(INT_ACK),
    .RMR_WR(RMR_WR), .RMR_DI(RMR_DI),
    .INT(INT), .HSYNC_OUT(HSYNC_OUT), .VSYNC_OUT(VSYNC_OUT),
    .MODE(MODE), .R52(R52)
  );

  always #5 CLOCK = ~CLOCK;

  int   checks = 0;
  int   failures = 0;
  int   hso_chars = 0;
  int   vso_falls = 0;
  logic last_hs = 1'b0;

  typedef struct { int start; int exp_int; int exp_r52; } rs_vec_t;
  typedef struct { int width; int exp_chars; } hs_vec_t;
  typedef struct { int lines; int exp_falls; } vs_vec_t;

  rs_vec_t rs_tab[4];
  hs_vec_t hs_tab[6];
  vs_vec_t vs_tab[4];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end else begin
      $display("ok   %s = %0d", name, act);
    end
  endtask

  // One character: inputs presented with CLKEN for one clock, then one idle clock.
  task automatic do_char(input logic hs, input logic vs);
    if (last_hs && !hs && VSYNC_OUT) vso_falls++;
    last_hs  = hs;
    HSYNC_IN = hs;
    VSYNC_IN = vs;
    CLKEN    = 1'b1;
    @(posedge CLOCK); #1;
    CLKEN = 1'b0;
    if (HSYNC_OUT) hso_chars++;
    @(posedge CLOCK); #1;
  endtask

  task automatic line(input int width, input int period, input logic vs);
    for (int c = 0; c < period; c++) do_char(c < width, vs);
  endtask

  task automatic lines(input int count, input logic vs);
    for (int i = 0; i < count; i++) line(4, 8, vs);
  endtask

  task automatic rmr(input logic [4:0] di);
    RMR_DI = di;
    RMR_WR = 1'b1;
    @(posedge CLOCK); #1;
    RMR_WR = 1'b0;
  endtask

  task automatic ack();
    INT_ACK = 1'b1;
    @(posedge CLOCK); #1;
    INT_ACK = 1'b0;
  endtask

  task automatic set_r52(input int v);
    rmr(5'h10);
    lines(v, 1'b0);
  endtask

  initial begin
    rs_tab[0] = '{start: 40, exp_int: 1, exp_r52: 0};
    rs_tab[1] = '{start: 10, exp_int: 0, exp_r52: 0};
    rs_tab[2] = '{start: 30, exp_int: 1, exp_r52: 0};
    rs_tab[3] = '{start: 29, exp_int: 0, exp_r52: 0};
`ifndef GA_VSYNC_IRQ_SYNC_EN
    rs_tab[0] = '{start: 40, exp_int: 0, exp_r52: 42};
    rs_tab[1] = '{start: 10, exp_int: 0, exp_r52: 12};
    rs_tab[2] = '{start: 30, exp_int: 0, exp_r52: 32};
    rs_tab[3] = '{start: 29, exp_int: 0, exp_r52: 31};
`endif
    hs_tab[0] = '{width: 14, exp_chars: 4};
    hs_tab[1] = '{width: 3,  exp_chars: 1};
    hs_tab[2] = '{width: 2,  exp_chars: 0};
    hs_tab[3] = '{width: 1,  exp_chars: 0};
    hs_tab[4] = '{width: 5,  exp_chars: 3};
    hs_tab[5] = '{width: 6,  exp_chars: 4};
    vs_tab[0] = '{lines: 30, exp_falls: 26};
    vs_tab[1] = '{lines: 8,  exp_falls: 8};
    vs_tab[2] = '{lines: 26, exp_falls: 26};
    vs_tab[3] = '{lines: 27, exp_falls: 26};

    // Reset state
    repeat (3) @(posedge CLOCK);
    #1;
    chk("rst_int", INT, 0);
    chk("rst_hso", HSYNC_OUT, 0);
    chk("rst_vso", VSYNC_OUT, 0);
    chk("rst_mode", MODE, 0);
    chk("rst_r52", R52, 0);
    nRESET = 1'b1;
    @(posedge CLOCK); #1;

    // 52 full-size lines raise INT on the 52nd fall
    for (int i = 0; i < 51; i++) line(14, 64, 1'b0);
    chk("l51_r52", R52, 51);
    chk("l51_int", INT, 0);
    line(14, 64, 1'b0);
    chk("l52_int", INT, 1);
    chk("l52_r52", R52, 0);
    ack();
    chk("ack52_int", INT, 0);
    chk("ack52_r52", R52, 0);

    // VSYNC resync table
    for (int i = 0; i < 4; i++) begin
      set_r52(rs_tab[i].start);
      line(4, 8, 1'b1);
      line(4, 8, 1'b1);
      chk($sformatf("resync%0d_int", rs_tab[i].start), INT, rs_tab[i].exp_int);
      chk($sformatf("resync%0d_r52", rs_tab[i].start), R52, rs_tab[i].exp_r52);
      lines(1, 1'b0);
    end

    // INT_ACK coincident with HS fall at R52=51: bit 5 cleared before increment
    set_r52(51);
    for (int c = 0; c < 4; c++) do_char(1'b1, 1'b0);
    HSYNC_IN = 1'b0; last_hs = 1'b0; CLKEN = 1'b1; INT_ACK = 1'b1;
    @(posedge CLOCK); #1;
    CLKEN = 1'b0; INT_ACK = 1'b0;
    chk("ackfall_r52", R52, 20);
    chk("ackfall_int", INT, 0);
    for (int c = 0; c < 3; c++) do_char(1'b0, 1'b0);

    // RMR reset beats the 52 wrap in the same clock
    set_r52(51);
    for (int c = 0; c < 4; c++) do_char(1'b1, 1'b0);
    HSYNC_IN = 1'b0; last_hs = 1'b0; CLKEN = 1'b1; RMR_WR = 1'b1; RMR_DI = 5'h10;
    @(posedge CLOCK); #1;
    CLKEN = 1'b0; RMR_WR = 1'b0;
    chk("rmrwrap_r52", R52, 0);
    chk("rmrwrap_int", INT, 0);
    for (int c = 0; c < 3; c++) do_char(1'b0, 1'b0);

    // INT_ACK alone at R52=37 with INT pending
    set_r52(52);
    lines(37, 1'b0);
    chk("pre_ack_int", INT, 1);
    ack();
    chk("ack37_r52", R52, 5);
    chk("ack37_int", INT, 0);

    // Mode latching and mid-frame RMR reset
    rmr(5'h01);
    chk("mode_pending", MODE, 0);
    line(4, 8, 1'b0);
    chk("mode_1", MODE, 1);
    lines(3, 1'b0);
    rmr(5'h12);
    chk("rmr12_r52", R52, 0);
    chk("rmr12_int", INT, 0);
    chk("rmr12_mode", MODE, 1);
    for (int c = 0; c < 3; c++) do_char(1'b0, 1'b0);
    chk("mode_before_rise", MODE, 1);
    do_char(1'b1, 1'b0);
    chk("mode_2", MODE, 2);
    for (int c = 1; c < 8; c++) do_char(c < 4, 1'b0);
    HSYNC_IN = 1'b1; last_hs = 1'b1; CLKEN = 1'b1; RMR_WR = 1'b1; RMR_DI = 5'h03;
    @(posedge CLOCK); #1;
    CLKEN = 1'b0; RMR_WR = 1'b0;
    @(posedge CLOCK); #1;
    chk("mode_same_cycle", MODE, 3);
    for (int c = 1; c < 8; c++) do_char(c < 4, 1'b0);

    // Monitor HSYNC width table
    for (int i = 0; i < 6; i++) begin
      hso_chars = 0;
      line(hs_tab[i].width, 20, 1'b0);
      chk($sformatf("hso_w%0d", hs_tab[i].width), hso_chars, hs_tab[i].exp_chars);
    end

    // Monitor VSYNC length table
    for (int i = 0; i < 4; i++) begin
      vso_falls = 0;
      lines(vs_tab[i].lines, 1'b1);
      lines(3, 1'b0);
      chk($sformatf("vso_l%0d", vs_tab[i].lines), vso_falls, vs_tab[i].exp_falls);
    end

    // Asynchronous reset in the middle of an HSYNC pulse
    rmr(5'h13);
    lines(52, 1'b0);
    lines(3, 1'b0);
    for (int c = 0; c < 3; c++) do_char(1'b1, 1'b1);
    chk("pre_rst_hso", HSYNC_OUT, 1);
    chk("pre_rst_vso", VSYNC_OUT, 1);
    chk("pre_rst_int", INT, 1);
    chk("pre_rst_mode", MODE, 3);
    chk("pre_rst_r52", R52, 3);
    #2;
    nRESET = 1'b0;
    #1;
    chk("arst_int", INT, 0);
    chk("arst_hso", HSYNC_OUT, 0);
    chk("arst_vso", VSYNC_OUT, 0);
    chk("arst_mode", MODE, 0);
    chk("arst_r52", R52, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
